// File: rtl/tank_scan_sequencer_if.sv
// Sensor bus and register-bank load port of the tank scan sequencer.
//   master : the sequencer (drives sns_req/sns_sel and ld_en/ld_data)
//   slave  : sensor front-end + register bank
// Signals:
//   sns_req  1  request to the shared sensor bus
//   sns_sel  2  channel being requested
//   sns_ack  1  sensor data valid
//   sns_data 8  sensor sample
//   ld_en    4  one-hot register load strobe
//   ld_data  8  data for the strobed register
interface tank_scan_sequencer_if;
    logic       sns_req;
    logic [1:0] sns_sel;
    logic       sns_ack;
    logic [7:0] sns_data;
    logic [3:0] ld_en;
    logic [7:0] ld_data;

    modport master (output sns_req, sns_sel, ld_en, ld_data,
                    input  sns_ack, sns_data);
    modport slave  (input  sns_req, sns_sel, ld_en, ld_data,
                    output sns_ack, sns_data);
endinterface

// File: rtl/tank_scan_sequencer.sv
// Round-robin sequencer that polls the shared sensor bus for channels 0..3
// (cleanliness, temperature, food storage, saltiness) and loads the matching
// 8-bit tank register. Unanswered requests are abandoned after TIMEOUT_CYC
// cycles and flagged in a sticky per-channel error vector.
//
// Optional feature: define TANK_ALARM_EN to compare each loaded sample
// against per-channel thresholds and drive the alarm flags; otherwise alarm
// is tied low and thr_lo/thr_hi are ignored.
//
// Ports:
//   CLK          clock, rising edge
//   reset        asynchronous active-low reset
//   enable       run continuous scans (sampled at scan start only)
//   bus          sensor req/ack bus + register load port (master side)
//   busy         high in any state other than IDLE
//   scan_done    1-cycle pulse after channel 3 is handled
//   timeout_err  sticky per-channel timeout flags
//   err_clr      clears timeout_err (a same-cycle set wins)
//   thr_lo/hi    per-channel thresholds, channel n at [8n+7:8n]
//   alarm        per-channel out-of-range flags
module tank_scan_sequencer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int SCAN_GAP    = 100
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         enable,
    tank_scan_sequencer_if.master        bus,
    output logic                         busy,
    output logic                         scan_done,
    output logic [3:0]                   timeout_err,
    input  logic                         err_clr,
    input  logic [31:0]                  thr_lo,
    input  logic [31:0]                  thr_hi,
    output logic [3:0]                   alarm
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // A zero-length gap still needs a 1-bit counter to stay legal.
    localparam int GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GLAST = GW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_LOAD, ST_NEXT, ST_GAP} state_t;

    state_t        state_q;
    logic [1:0]    ch_q;
    logic [TW-1:0] tcnt_q;
    logic [GW-1:0] gcnt_q;
    logic          req_q;
    logic [3:0]    ld_en_q;
    logic [7:0]    ld_data_q;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    terr_q;
    logic [3:0]    ch_oh_d;
    logic [1:0]    ch_inc_d;

    assign ch_oh_d  = 4'b0001 << ch_q;
    assign ch_inc_d = ch_q + 2'd1;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            req_q     <= 1'b0;
            ld_en_q   <= '0;
            ld_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            ld_en_q <= '0;
            // Bit sets below are later assignments, so they override the clear.
            if (err_clr) terr_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_REQ;
                        ch_q    <= '0;
                        tcnt_q  <= '0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so it beats a coincident timeout.
                    if (bus.sns_ack) begin
                        ld_data_q <= bus.sns_data;
                        ld_en_q   <= ch_oh_d;
                        req_q     <= 1'b0;
                        tcnt_q    <= '0;
                        state_q   <= ST_LOAD;
                    end else if (tcnt_q == TLAST) begin
                        terr_q[ch_q] <= 1'b1;
                        req_q        <= 1'b0;
                        tcnt_q       <= '0;
                        done_q       <= (ch_q == 2'd3);
                        state_q      <= ST_NEXT;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    // scan_done is raised on entry so it is visible during NEXT.
                    done_q  <= (ch_q == 2'd3);
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (ch_q != 2'd3) begin
                        ch_q    <= ch_inc_d;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end else begin
                        ch_q    <= '0;
                        gcnt_q  <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt_q == GLAST) begin
                        gcnt_q <= '0;
                        if (enable) begin
                            req_q   <= 1'b1;
                            tcnt_q  <= '0;
                            state_q <= ST_REQ;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TANK_ALARM_EN
    logic [3:0] alarm_q;

    // Evaluated on the captured sample while it is being loaded; a timeout
    // never reaches LOAD, so it leaves the channel's flag untouched.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            alarm_q <= '0;
        end else if (state_q == ST_LOAD) begin
            alarm_q[ch_q] <= (ld_data_q < thr_lo[8*ch_q +: 8]) ||
                             (ld_data_q > thr_hi[8*ch_q +: 8]);
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_thr;
    assign unused_thr = ^{thr_lo, thr_hi};
    assign alarm      = 4'b0000;
`endif

    assign bus.sns_req  = req_q;
    assign bus.sns_sel  = ch_q;
    assign bus.ld_en    = ld_en_q;
    assign bus.ld_data  = ld_data_q;
    assign busy         = busy_q;
    assign scan_done    = done_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_tank_scan_sequencer.sv
// Scoreboard bench for tank_scan_sequencer: a sensor model acks requests,
// pushes the expected register load, and a monitor pops and compares loads.
module tb_tank_scan_sequencer;
    localparam int TO      = 16;
    localparam int GAP     = 6;
    localparam int ACK_DLY = 2;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] thr_lo = '0;
    logic [31:0] thr_hi = '1;
    logic        busy, scan_done;
    logic [3:0]  timeout_err, alarm;

    tank_scan_sequencer_if bus();

    tank_scan_sequencer #(.TIMEOUT_CYC(TO), .SCAN_GAP(GAP)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .bus(bus),
        .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err),
        .err_clr(err_clr), .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm(alarm)
    );

    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_done  = 0;
    int         n_loads = 0;
    int         req_len = 0;
    logic [1:0] last_sel = '0;
    logic [7:0] dat [4];
    logic [3:0] noack = '0;
    bit         stray = 1'b0;
    bit         exp_ld = 1'b0;
    logic [3:0] exp_alarm = '0;
    exp_t       sbq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sensor model + load monitor in one process so ordering is fixed.
    always @(negedge CLK) begin
        if (!reset) begin
            exp_ld       = 1'b0;
            req_len      = 0;
            bus.sns_ack  = 1'b0;
            bus.sns_data = '0;
        end else begin
            exp_t e;
            if (scan_done) n_done++;
            if (exp_ld) begin
                e = sbq.pop_front();
                chk("ld_en", 32'(bus.ld_en), 32'(4'b0001 << e.ch));
                chk("ld_data", 32'(bus.ld_data), 32'(e.d));
                n_loads++;
`ifdef TANK_ALARM_EN
                exp_alarm[e.ch] = (e.d < thr_lo[8*e.ch +: 8]) || (e.d > thr_hi[8*e.ch +: 8]);
`endif
            end else if (bus.ld_en != 4'b0000) begin
                chk("ld_unexp", 32'(bus.ld_en), 32'h0);
            end
            exp_ld = 1'b0;
            if (bus.sns_req) begin
                req_len++;
                last_sel = bus.sns_sel;
            end else if (req_len != 0) begin
                if (noack[last_sel]) chk("to_len", req_len, TO);
                else                 chk("ack_len", req_len, ACK_DLY);
                req_len = 0;
            end
            bus.sns_ack = 1'b0;
            if (bus.sns_req && !noack[bus.sns_sel] && req_len == ACK_DLY) begin
                bus.sns_ack  = 1'b1;
                bus.sns_data = dat[bus.sns_sel];
                e.ch = bus.sns_sel;
                e.d  = dat[bus.sns_sel];
                sbq.push_back(e);
                exp_ld = 1'b1;
            end else if (!bus.sns_req && stray) begin
                // Ack with no request outstanding must be ignored.
                bus.sns_ack  = 1'b1;
                bus.sns_data = 8'hEE;
            end
        end
    end

    task automatic wait_sel(input logic [1:0] s);
        int i = 0;
        while (!(bus.sns_req && bus.sns_sel == s) && i < 300) begin
            @(negedge CLK);
            i++;
        end
        if (i >= 300) chk("wait_sel_tmo", 32'h0, 32'h1);
    endtask

    task automatic finish_scan();
        int i = 0;
        while (n_done == 0 && i < 400) begin
            @(negedge CLK);
            i++;
        end
        if (n_done == 0) chk("done_tmo", 32'h0, 32'h1);
        enable = 1'b0;
        i = 0;
        while (busy && i < 200) begin
            @(negedge CLK);
            i++;
        end
        if (busy) chk("idle_tmo", 32'h0, 32'h1);
        repeat (2) @(negedge CLK);
        chk("sbq_empty", sbq.size(), 0);
    endtask

    task automatic run_scan();
        n_done  = 0;
        n_loads = 0;
        enable  = 1'b1;
        finish_scan();
    endtask

    initial begin
        int k;
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        repeat (3) @(negedge CLK);
        chk("rst_req", 32'(bus.sns_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ld_en", 32'(bus.ld_en), 0);
        chk("rst_ld_data", 32'(bus.ld_data), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_done", 32'(scan_done), 0);
        chk("rst_alarm", 32'(alarm), 0);
        reset = 1'b1;
        stray = 1'b1;
        repeat (2) @(negedge CLK);

        // Clean scan, all four channels answered.
        run_scan();
        chk("t2_loads", n_loads, 4);
        chk("t2_done", n_done, 1);
        chk("t2_terr", 32'(timeout_err), 0);

        // Channel 2 silent: abandoned, others still loaded.
        noack = 4'b0100;
        run_scan();
        chk("t3_terr", 32'(timeout_err), 32'h4);
        chk("t3_loads", n_loads, 3);
        chk("t3_done", n_done, 1);

        // err_clr on the exact cycle channel 1 times out.
        noack   = 4'b0010;
        n_done  = 0;
        n_loads = 0;
        enable  = 1'b1;
        wait_sel(2'd1);
        repeat (TO - 1) @(negedge CLK);
        chk("t4_pre", 32'(timeout_err), 32'h4);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("t4_terr", 32'(timeout_err), 32'h2);
        finish_scan();
        chk("t4_loads", n_loads, 3);

        // enable dropped during channel 1: scan completes, gap, then idle.
        noack   = '0;
        n_done  = 0;
        n_loads = 0;
        enable  = 1'b1;
        wait_sel(2'd1);
        enable = 1'b0;
        k = 0;
        while (!scan_done && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk("t5_done_seen", 32'(scan_done), 1);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (busy && k < 50);
        chk("t5_gap_len", k, GAP + 1);
        repeat (8) @(negedge CLK);
        chk("t5_req", 32'(bus.sns_req), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_loads", n_loads, 4);
        chk("t5_done", n_done, 1);

        // Threshold alarms; ch0 sits exactly on both limits, ch3 below low.
        thr_lo = 32'h50_00_18_11;
        thr_hi = 32'hFF_FF_1E_11;
        dat[1] = 8'h20;
        run_scan();
        chk("t6_alarm_a", 32'(alarm), 32'(exp_alarm));
`ifdef TANK_ALARM_EN
        chk("t6_alarm1_hi", 32'(alarm[1]), 1);
`else
        chk("t6_alarm1_hi", 32'(alarm[1]), 0);
`endif
        dat[1] = 8'h1A;
        run_scan();
        chk("t6_alarm_b", 32'(alarm), 32'(exp_alarm));
        chk("t6_alarm1_in", 32'(alarm[1]), 0);

        // Async reset while a request is outstanding.
        enable = 1'b1;
        wait_sel(2'd0);
        #2 reset = 1'b0;
        #1;
        chk("t1_req", 32'(bus.sns_req), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_ld_en", 32'(bus.ld_en), 0);
        chk("t1_terr", 32'(timeout_err), 0);
        chk("t1_alarm", 32'(alarm), 0);
        enable = 1'b0;
        sbq.delete();
        exp_alarm = '0;
        repeat (2) @(negedge CLK);
        #2 reset = 1'b1;
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
